ps2_pkt_sched: RTL and testbench
================================

# ps2_pkt_sched

Packet-level controller for the PS/2 mouse receive path.
- Accepts the byte stream from the PS/2 byte receiver, frames 3-byte packets by recovering sync on bit 3 of the first byte, and aborts stale partial packets on an inter-byte timeout.
- Queues completed packets in a 2-entry buffer toward the host-side consumer over a valid/ready handshake, counting packets dropped on overflow.

## Interface
- TIMEOUT, default 1000: idle cycles allowed between bytes of one packet before abort; legal range 2 to 2^20.
- CNT_W, default 8: width of the drop counter.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low (reset==0 resets on the clock edge).
- in_valid  in  1  one-cycle strobe, in_data holds a received byte.
- in_data  in  8  received byte.
- pkt_valid  out  1  buffer head holds a complete packet.
- pkt_ready  in  1  consumer accepts head this cycle.
- pkt_data  out  24  {byte1, byte2, byte3}, byte1 in [23:16].
- sync_err  out  1  one-cycle pulse: byte discarded while hunting, or partial packet aborted.
- drop_cnt  out  CNT_W  saturating count of completed packets lost to a full buffer.
- clr_cnt  in  1  clears drop_cnt.

## Operation
- FSM states:
  - HUNT: in_valid with in_data[3]==1 stores byte1 and moves to GOT1; in_valid with in_data[3]==0 discards the byte and pulses sync_err.
  - GOT1: in_valid stores byte2 and moves to GOT2.
  - GOT2: in_valid stores byte3, pushes {b1,b2,b3} and returns to HUNT. Bit 3 is not checked on bytes 2 and 3.
- Timeout:
  - Idle counter runs only in GOT1/GOT2; it clears on every accepted byte and on entry to HUNT.
  - After TIMEOUT consecutive cycles without in_valid, the FSM returns to HUNT, the partial packet is discarded, and sync_err pulses.
  - If in_valid arrives in the cycle the count would reach TIMEOUT, the byte wins; no abort occurs.
- Buffer: 2-entry FIFO.
  - Pop on pkt_valid && pkt_ready.
  - A push while full without a same-cycle pop is dropped; drop_cnt increments, saturating at all-ones.
  - Full with simultaneous pop and push: push is accepted, occupancy stays 2.
  - Occupancy 1 with simultaneous push and pop: occupancy stays 1 and the new packet becomes head.
- Handshake: pkt_data is stable while pkt_valid && !pkt_ready. pkt_valid never drops without a pop.
- clr_cnt: drop_cnt becomes 0 on the next edge. Clear wins over a simultaneous drop.
- Reset (reset==0): FSM goes to HUNT, timer 0, FIFO empty, pkt_valid 0, pkt_data 0, sync_err 0, drop_cnt 0. A partial packet or queued packets are lost; in_valid during reset is ignored.

## Timing
- All outputs are registered.
- Packet latency: third byte's in_valid at edge N gives pkt_valid=1 with pkt_data valid after edge N, i.e. in cycle N+1, when the FIFO was empty.
- sync_err asserts in the cycle after the offending byte or timeout edge, for exactly one cycle.
- Back-to-back bytes (in_valid every cycle) are supported: one packet per 3 cycles.
- Sustained throughput: with pkt_ready held high, one packet per 3 cycles with no drops.

## Structure
- Package ps2_pkg holds:
  - state enum {HUNT, GOT1, GOT2}
  - BYTE_W=8
  - PKT_W=24
  - SYNC_BIT=3
- One sub-module: ps2_pkt_fifo, a 2-entry, PKT_W-wide FIFO with push/pop/full/empty, instantiated once.
- FSM, timer and drop counter live in ps2_pkt_sched.

## Test plan
- Bytes 0x08,0x12,0x34 on consecutive cycles, pkt_ready=1 -> pkt_valid one cycle later with pkt_data=0x081234; sync_err never asserted.
- Bytes 0x00,0x01,0x08,0xAA,0xBB -> two sync_err pulses (for 0x00 and 0x01), then pkt_data=0x08AABB.
- TIMEOUT=10, byte 0x08 then 10 idle cycles, then 0x18,0x01,0x02 -> sync_err once at abort, then pkt_data=0x180102; no packet containing 0x08.
- pkt_ready=0 with four packets sent -> first two held in order, drop_cnt=2. Then pkt_ready=1 -> exactly two pops. clr_cnt -> drop_cnt=0.
- FIFO full, pop and third-byte push in the same cycle -> drop_cnt unchanged, occupancy 2, order preserved.
- reset=0 asserted after byte2 with one packet queued -> pkt_valid=0, drop_cnt=0, FSM in HUNT. Bytes 0x09,0x01,0x02 after release -> pkt_data=0x090102.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and widths for the PS/2 mouse packet path.
//   state_e : framing FSM states
//   pkt_t   : 3-byte packet payload, byte1 in the most significant byte
package ps2_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned PKT_W    = 24;
    localparam int unsigned SYNC_BIT = 3;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        GOT1 = 2'd1,
        GOT2 = 2'd2
    } state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] b1;
        logic [BYTE_W-1:0] b2;
        logic [BYTE_W-1:0] b3;
    } pkt_t;

endpackage

// File: rtl/ps2_pkt_fifo.sv
// Two-entry packet FIFO; entry 0 is always the head.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   push, din  : write request and packet; ignored when full unless popping
//   pop        : remove head; ignored when empty
//   head       : current head packet (registered)
//   full/empty : registered occupancy flags
module ps2_pkt_fifo
    import ps2_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [PKT_W-1:0] din,
    input  logic             pop,
    output logic [PKT_W-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [PKT_W-1:0] ent1;
    logic             pop_ok;
    logic             push_ok;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Storage and occupancy flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            ent1  <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (empty) begin
                        head  <= din;
                        empty <= 1'b0;
                    end else begin
                        ent1 <= din;
                        full <= 1'b1;
                    end
                end
                2'b01: begin
                    if (full) begin
                        head <= ent1;
                        full <= 1'b0;
                    end else begin
                        empty <= 1'b1;
                    end
                end
                2'b11: begin
                    if (full) begin
                        head <= ent1;
                        ent1 <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ps2_pkt_sched.sv
// PS/2 mouse packet framer and host-side queue.
// Frames 3-byte packets (sync on bit 3 of byte 1), aborts partial packets
// after TIMEOUT idle cycles, and queues packets in a 2-entry FIFO.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   in_valid, in_data   : byte strobe and byte from the PS/2 receiver
//   pkt_valid/ready/data: packet handshake toward the host, {b1,b2,b3}
//   sync_err            : one-cycle pulse on discarded byte or aborted packet
//   drop_cnt, clr_cnt   : saturating overflow drop counter and its clear
module ps2_pkt_sched
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic [PKT_W-1:0]  pkt_data,
    output logic              sync_err,
    output logic [CNT_W-1:0]  drop_cnt,
    input  logic              clr_cnt
);

    localparam int unsigned      TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_e            state;
    state_e            state_nxt;
    logic [TMR_W-1:0]  timer;
    logic [BYTE_W-1:0] byte1_q;
    logic [BYTE_W-1:0] byte2_q;
    logic              hunt_bad_c;
    logic              timeout_c;
    logic              push_c;
    logic              pop_c;
    logic              drop_c;
    logic              fifo_full;
    logic              fifo_empty;
    pkt_t              pkt_c;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; an arriving byte always beats the timeout.
    always_comb begin
        state_nxt  = state;
        hunt_bad_c = 1'b0;
        timeout_c  = 1'b0;
        push_c     = 1'b0;
        case (state)
            HUNT: begin
                if (in_valid) begin
                    if (in_data[SYNC_BIT]) begin
                        state_nxt = GOT1;
                    end else begin
                        hunt_bad_c = 1'b1;
                    end
                end
            end
            GOT1: begin
                if (in_valid) begin
                    state_nxt = GOT2;
                end else if (timer == TMR_LAST) begin
                    state_nxt = HUNT;
                    timeout_c = 1'b1;
                end
            end
            GOT2: begin
                if (in_valid) begin
                    state_nxt = HUNT;
                    push_c    = 1'b1;
                end else if (timer == TMR_LAST) begin
                    state_nxt = HUNT;
                    timeout_c = 1'b1;
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    // Idle timer, captured bytes and error pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            timer    <= '0;
            byte1_q  <= '0;
            byte2_q  <= '0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= hunt_bad_c | timeout_c;
            if (in_valid || state_nxt == HUNT) begin
                timer <= '0;
            end else begin
                timer <= timer + TMR_W'(1);
            end
            if (state == HUNT && in_valid) begin
                byte1_q <= in_data;
            end
            if (state == GOT1 && in_valid) begin
                byte2_q <= in_data;
            end
        end
    end

    // Third byte is pushed straight from the input so the packet is visible next cycle.
    assign pkt_c  = '{b1: byte1_q, b2: byte2_q, b3: in_data};
    assign pop_c  = pkt_ready && !fifo_empty;
    assign drop_c = push_c && fifo_full && !pop_c;

    ps2_pkt_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .din   (PKT_W'(pkt_c)),
        .pop   (pop_c),
        .head  (pkt_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pkt_valid = !fifo_empty;

    // Drop counter; clear has priority over a same-cycle drop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (clr_cnt) begin
            drop_cnt <= '0;
        end else if (drop_c && !(&drop_cnt)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ps2_pkt_sched.sv
// Self-checking bench for ps2_pkt_sched (TIMEOUT=10).
module tb_ps2_pkt_sched;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [23:0] pkt_data;
    logic        sync_err;
    logic [7:0]  drop_cnt;
    logic        clr_cnt;

    ps2_pkt_sched #(.TIMEOUT(10), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_data  (pkt_data),
        .sync_err  (sync_err),
        .drop_cnt  (drop_cnt),
        .clr_cnt   (clr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        err;
        logic        push;
        logic [23:0] pkt;
    } vec_t;

    vec_t        vecs[$];
    logic [23:0] sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          pops   = 0;
    logic        hold_q = 1'b0;
    logic [23:0] hold_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic e,
                       input logic p, input logic [23:0] k);
        vec_t r;
        r.v = v; r.d = d; r.err = e; r.push = p; r.pkt = k;
        vecs.push_back(r);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add(1'b0, 8'h00, 1'b0, 1'b0, 24'h0);
    endtask

    // Inputs change 1 time unit after an edge and are sampled by the next edge.
    task automatic step(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        step(1'b1, a);
        step(1'b1, b);
        step(1'b1, c);
    endtask

    // Scoreboard monitor: compare every popped head and check holds while stalled.
    always @(negedge clk) begin
        if (reset) begin
            if (hold_q) begin
                chk("hold_valid", 32'(pkt_valid), 32'd1);
                chk("hold_data", 32'(pkt_data), 32'(hold_data));
            end
            if (pkt_valid && pkt_ready) begin
                pops++;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got %h expected none", pkt_data);
                end else begin
                    chk("pop_data", 32'(pkt_data), 32'(sb.pop_front()));
                end
            end
            hold_q    = pkt_valid && !pkt_ready;
            hold_data = pkt_data;
        end else begin
            hold_q = 1'b0;
        end
    end

    int pops0;

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        pkt_ready = 1'b0;
        clr_cnt   = 1'b0;

        // Reset with bytes arriving, which must be ignored.
        repeat (3) step(1'b1, 8'h08);
        chk("rst_valid", 32'(pkt_valid), 32'd0);
        chk("rst_data", 32'(pkt_data), 32'd0);
        chk("rst_err", 32'(sync_err), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        reset = 1'b1;
        step(1'b0, 8'h00);

        // Vector table: basic packet, resync, timeout, byte-wins, unchecked bit 3, back-to-back.
        add(1, 8'h08, 0, 0, 0); add(1, 8'h12, 0, 0, 0); add(1, 8'h34, 0, 1, 24'h081234);
        add_idle(2);
        add(1, 8'h00, 1, 0, 0); add(1, 8'h01, 1, 0, 0);
        add(1, 8'h08, 0, 0, 0); add(1, 8'hAA, 0, 0, 0); add(1, 8'hBB, 0, 1, 24'h08AABB);
        add_idle(2);
        add(1, 8'h08, 0, 0, 0); add_idle(9); add(0, 8'h00, 1, 0, 0); add_idle(1);
        add(1, 8'h18, 0, 0, 0); add(1, 8'h01, 0, 0, 0); add(1, 8'h02, 0, 1, 24'h180102);
        add_idle(2);
        add(1, 8'h08, 0, 0, 0); add_idle(9); add(1, 8'h01, 0, 0, 0);
        add_idle(9); add(1, 8'h02, 0, 1, 24'h080102);
        add_idle(1);
        add(1, 8'h18, 0, 0, 0); add(1, 8'h00, 0, 0, 0); add(1, 8'h00, 0, 1, 24'h180000);
        add(1, 8'h08, 0, 0, 0); add(1, 8'h01, 0, 0, 0); add(1, 8'h02, 0, 1, 24'h080102);
        add(1, 8'h0F, 0, 0, 0); add(1, 8'h03, 0, 0, 0); add(1, 8'h04, 0, 1, 24'h0F0304);
        add_idle(3);

        pkt_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].push) sb.push_back(vecs[i].pkt);
            step(vecs[i].v, vecs[i].d);
            chk($sformatf("v%0d_sync_err", i), 32'(sync_err), 32'(vecs[i].err));
            if (vecs[i].push) begin
                chk($sformatf("v%0d_lat_valid", i), 32'(pkt_valid), 32'd1);
                chk($sformatf("v%0d_lat_data", i), 32'(pkt_data), 32'(vecs[i].pkt));
            end
        end
        chk("table_drained", 32'(sb.size()), 32'd0);
        chk("table_drop", 32'(drop_cnt), 32'd0);

        // Overflow: four packets with the consumer stalled.
        pkt_ready = 1'b0;
        sb.push_back(24'h081122); send_pkt(8'h08, 8'h11, 8'h22);
        sb.push_back(24'h093344); send_pkt(8'h09, 8'h33, 8'h44);
        send_pkt(8'h0A, 8'h55, 8'h66);
        send_pkt(8'h0B, 8'h77, 8'h88);
        step(1'b0, 8'h00);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        chk("ovf_valid", 32'(pkt_valid), 32'd1);
        chk("ovf_head", 32'(pkt_data), 32'h081122);
        pops0 = pops;
        pkt_ready = 1'b1;
        repeat (4) step(1'b0, 8'h00);
        chk("ovf_pops", 32'(pops - pops0), 32'd2);
        chk("ovf_empty", 32'(pkt_valid), 32'd0);
        clr_cnt = 1'b1;
        step(1'b0, 8'h00);
        clr_cnt = 1'b0;
        chk("clr_drop", 32'(drop_cnt), 32'd0);

        // Occupancy 1 with push+pop, then full with push+pop, then clear vs drop.
        pkt_ready = 1'b0;
        sb.push_back(24'h0C0101); send_pkt(8'h0C, 8'h01, 8'h01);
        sb.push_back(24'h0D0202);
        step(1'b1, 8'h0D); step(1'b1, 8'h02);
        pkt_ready = 1'b1;
        step(1'b1, 8'h02);
        pkt_ready = 1'b0;
        chk("occ1_valid", 32'(pkt_valid), 32'd1);
        chk("occ1_head", 32'(pkt_data), 32'h0D0202);
        sb.push_back(24'h0E0303); send_pkt(8'h0E, 8'h03, 8'h03);
        sb.push_back(24'h0F0404);
        step(1'b1, 8'h0F); step(1'b1, 8'h04);
        pkt_ready = 1'b1;
        step(1'b1, 8'h04);
        pkt_ready = 1'b0;
        chk("full_pp_drop", 32'(drop_cnt), 32'd0);
        chk("full_pp_head", 32'(pkt_data), 32'h0E0303);
        send_pkt(8'h08, 8'h05, 8'h05);
        chk("full_pp_occ2", 32'(drop_cnt), 32'd1);
        step(1'b1, 8'h08); step(1'b1, 8'h06);
        clr_cnt = 1'b1;
        step(1'b1, 8'h06);
        clr_cnt = 1'b0;
        chk("clr_wins", 32'(drop_cnt), 32'd0);
        pkt_ready = 1'b1;
        repeat (4) step(1'b0, 8'h00);
        chk("order_drained", 32'(sb.size()), 32'd0);

        // Reset in the middle of a packet with data queued.
        pkt_ready = 1'b0;
        sb.push_back(24'h08AA01); send_pkt(8'h08, 8'hAA, 8'h01);
        sb.push_back(24'h08AA02); send_pkt(8'h08, 8'hAA, 8'h02);
        send_pkt(8'h08, 8'hAA, 8'h03);
        chk("pre_rst_drop", 32'(drop_cnt), 32'd1);
        step(1'b1, 8'h0C); step(1'b1, 8'h21);
        reset = 1'b0;
        step(1'b1, 8'h08);
        step(1'b1, 8'h08);
        chk("mid_rst_valid", 32'(pkt_valid), 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        chk("mid_rst_data", 32'(pkt_data), 32'd0);
        sb.delete();
        reset = 1'b1;
        step(1'b1, 8'h21);
        chk("post_rst_hunt", 32'(sync_err), 32'd1);
        pkt_ready = 1'b1;
        step(1'b1, 8'h09); step(1'b1, 8'h01);
        sb.push_back(24'h090102);
        step(1'b1, 8'h02);
        chk("post_rst_valid", 32'(pkt_valid), 32'd1);
        chk("post_rst_data", 32'(pkt_data), 32'h090102);
        repeat (3) step(1'b0, 8'h00);
        chk("final_drained", 32'(sb.size()), 32'd0);
        chk("final_valid", 32'(pkt_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
